// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the mux scan sequencer and its surroundings
// (the 4:1 mux datapath on one side, counter/display logic on the other).
interface mux_scan_ctrl_if;
  logic       en;
  logic [3:0] ch_mask;
  logic       mux_y;
  logic [1:0] sel;
  logic       mux_en;
  logic [3:0] sample;
  logic       sample_valid;
  logic       busy;

  // master: the environment that requests scans and supplies the mux output
  modport master (
    output en, ch_mask, mux_y,
    input  sel, mux_en, sample, sample_valid, busy
  );

  // slave: the sequencer itself
  modport slave (
    input  en, ch_mask, mux_y,
    output sel, mux_en, sample, sample_valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for a 4:1 mux: blanks the enable around each
// select change, samples Y per channel and publishes one word per full sweep.
module mux_scan_ctrl #(
  parameter int DIV   = 4,
  parameter int BLANK = 2,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  localparam int BLANK_LAST_I = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int DIV_LAST_I   = (DIV > 0) ? DIV - 1 : 0;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_LAST_I);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_LAST_I);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       done_q;
  logic [3:0]       shadow_q;
  logic [3:0]       sample_q;
  logic [1:0]       sel_q;
  logic             mux_en_q;
  logic             valid_q;
  logic             busy_q;

  logic [3:0]       done_d;
  logic [3:0]       shadow_d;
  logic             sweep_done_d;
  logic [1:0]       sel_adv_d;

  function automatic logic [1:0] first_sel(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Nearest set bit above cur, wrapping; returns cur when it is the only one.
  function automatic logic [1:0] next_sel(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  always_comb begin
    done_d          = done_q | (4'b0001 << sel_q);
    shadow_d        = shadow_q;
    shadow_d[sel_q] = bus.mux_y;
    sweep_done_d    = ((done_d & bus.ch_mask) == bus.ch_mask);
    sel_adv_d       = next_sel(bus.ch_mask, sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      sel_q    <= '0;
      mux_en_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          mux_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= '0;
          cnt_q    <= '0;
          if (bus.en && (bus.ch_mask != 4'b0000)) begin
            sel_q  <= first_sel(bus.ch_mask);
            busy_q <= 1'b1;
            if (BLANK == 0) begin
              state_q  <= ST_DRIVE;
              mux_en_q <= 1'b1;
            end else begin
              state_q  <= ST_BLANK;
            end
          end
        end

        ST_BLANK: begin
          if (!bus.en) begin
            state_q  <= ST_IDLE;
            mux_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
            cnt_q    <= '0;
          end else if (cnt_q == BLANK_LAST) begin
            state_q  <= ST_DRIVE;
            mux_en_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DRIVE: begin
          // Abort takes priority over a capture landing on the same edge.
          if (!bus.en) begin
            state_q  <= ST_IDLE;
            mux_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
            cnt_q    <= '0;
          end else if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (bus.ch_mask == 4'b0000) begin
              state_q  <= ST_IDLE;
              mux_en_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= '0;
            end else begin
              shadow_q <= shadow_d;
              sel_q    <= sel_adv_d;
              if (sweep_done_d) begin
                sample_q <= shadow_d & bus.ch_mask;
                valid_q  <= 1'b1;
                done_q   <= '0;
              end else begin
                done_q   <= done_d;
              end
              // Without a gap the enable stays high straight into the next dwell.
              if (BLANK == 0) begin
                state_q  <= ST_DRIVE;
                mux_en_q <= 1'b1;
              end else begin
                state_q  <= ST_BLANK;
                mux_en_q <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          mux_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= '0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.sel          = sel_q;
  assign bus.mux_en       = mux_en_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a gapped build (BLANK=2) and a gapless
// build (BLANK=0), each fed by a behavioural 4:1 mux, with a sample scoreboard.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_ctrl_if bus ();
  mux_scan_ctrl_if bus0 ();

  logic [3:0] iv;
  logic [3:0] iv0;

  assign bus.mux_y  = iv[bus.sel];
  assign bus0.mux_y = iv0[bus0.sel];

  mux_scan_ctrl #(.DIV(4), .BLANK(2), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux_scan_ctrl #(.DIV(4), .BLANK(0), .CNT_W(16)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp0_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop for the gapped build
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && bus.sample_valid) begin
      chk("sb_a_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_a_sample", 32'(bus.sample), 32'(e));
      end
    end
  end

  // Scoreboard pop for the gapless build
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && bus0.sample_valid) begin
      chk("sb_b_pending", 32'(exp0_q.size() != 0), 32'd1);
      if (exp0_q.size() != 0) begin
        e = exp0_q.pop_front();
        chk("sb_b_sample", 32'(bus0.sample), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    iv           = 4'b1010;
    iv0          = 4'b0000;
    bus.en       = 1'b1;
    bus.ch_mask  = 4'b1111;
    bus0.en      = 1'b0;
    bus0.ch_mask = 4'b0000;

    // Reset held with en high
    repeat (3) @(negedge clk);
    chk("rst_sel",    32'(bus.sel),          32'd0);
    chk("rst_mux_en", 32'(bus.mux_en),       32'd0);
    chk("rst_sample", 32'(bus.sample),       32'd0);
    chk("rst_busy",   32'(bus.busy),         32'd0);
    chk("rst_valid",  32'(bus.sample_valid), 32'd0);

    // Full sweep, mask 1111, I=1010, two sweeps
    rst_n = 1'b1;
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1010);
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      if (k == 1) chk("t2_busy_k1", 32'(bus.busy), 32'd1);
      chk($sformatf("t2_sel_k%0d", k),    32'(bus.sel),          32'(((k - 1) % 24) / 6));
      chk($sformatf("t2_muxen_k%0d", k),  32'(bus.mux_en),       32'(((k - 1) % 6) >= 2));
      chk($sformatf("t2_valid_k%0d", k),  32'(bus.sample_valid), 32'((k == 25) || (k == 49)));
    end

    // Sparse mask 0101, I=0100
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    bus.ch_mask = 4'b0101;
    iv = 4'b0100;
    repeat (3) exp_q.push_back(4'b0100);
    bus.en = 1'b1;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      chk($sformatf("t3_sel_k%0d", k),   32'(bus.sel),          32'(((((k - 1) / 6) % 2) == 1) ? 2 : 0));
      chk($sformatf("t3_muxen_k%0d", k), 32'(bus.mux_en),       32'(((k - 1) % 6) >= 2));
      chk($sformatf("t3_valid_k%0d", k), 32'(bus.sample_valid), 32'((k % 12) == 1 && k > 1));
    end

    // Abort on DRIVE cycle 2 of channel 2
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    bus.ch_mask = 4'b1111;
    iv = 4'b1010;
    bus.en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("t4_sel_k%0d", k),   32'(bus.sel),          32'((k - 1) / 6));
      chk($sformatf("t4_muxen_k%0d", k), 32'(bus.mux_en),       32'(((k - 1) % 6) >= 2));
      chk($sformatf("t4_valid_k%0d", k), 32'(bus.sample_valid), 32'd0);
    end
    bus.en = 1'b0;
    @(negedge clk);
    chk("t4_abort_muxen", 32'(bus.mux_en), 32'd0);
    chk("t4_abort_busy",  32'(bus.busy),   32'd0);
    chk("t4_abort_sel",   32'(bus.sel),    32'd2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("t4_idle_valid_%0d", k), 32'(bus.sample_valid), 32'd0);
      chk($sformatf("t4_idle_busy_%0d", k),  32'(bus.busy),         32'd0);
    end
    chk("t4_sample_kept", 32'(bus.sample), 32'(4'b0100));

    // Restart, then shrink mask 1111 -> 0011 during channel 1 DRIVE
    iv = 4'b1111;
    bus.en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) chk("t5_busy_k1", 32'(bus.busy), 32'd1);
      chk($sformatf("t5_sel_k%0d", k),   32'(bus.sel),
          32'((k <= 12) ? ((k - 1) / 6) : (((k - 13) / 6) % 2)));
      chk($sformatf("t5_muxen_k%0d", k), 32'(bus.mux_en),       32'(((k - 1) % 6) >= 2));
      chk($sformatf("t5_valid_k%0d", k), 32'(bus.sample_valid), 32'((k == 13) || (k == 25)));
      if (k == 10) begin
        bus.ch_mask = 4'b0011;
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0011);
      end
    end
    bus.en = 1'b0;
    repeat (2) @(negedge clk);

    // en high with an empty mask stays idle
    bus.ch_mask = 4'b0000;
    bus.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t0mask_busy_%0d", k),  32'(bus.busy),   32'd0);
      chk($sformatf("t0mask_muxen_%0d", k), 32'(bus.mux_en), 32'd0);
    end
    bus.en = 1'b0;

    // Gapless build, single channel 3
    iv0 = 4'b1000;
    bus0.ch_mask = 4'b1000;
    repeat (3) exp0_q.push_back(4'b1000);
    bus0.en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk($sformatf("t6_sel_k%0d", k),   32'(bus0.sel),          32'd3);
      chk($sformatf("t6_muxen_k%0d", k), 32'(bus0.mux_en),       32'd1);
      chk($sformatf("t6_busy_k%0d", k),  32'(bus0.busy),         32'd1);
      chk($sformatf("t6_valid_k%0d", k), 32'(bus0.sample_valid), 32'((k % 4) == 1 && k > 1));
    end

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel",      32'(bus0.sel),    32'd0);
    chk("arst_mux_en",   32'(bus0.mux_en), 32'd0);
    chk("arst_sample",   32'(bus0.sample), 32'd0);
    chk("arst_busy",     32'(bus0.busy),   32'd0);
    chk("arst_sample_a", 32'(bus.sample),  32'd0);

    chk("sb_a_drained", 32'(exp_q.size()),  32'd0);
    chk("sb_b_drained", 32'(exp0_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer for the 4:1 mux datapath (I[3:0], S[1:0], E, Y) in the Dem_0_9 design.
- Steps the mux select round-robin over enabled channels, with an enable-blanking gap at each select change.
- Samples Y at the end of each dwell and rebuilds the four input bits into a register.
- Publishes the register once per completed sweep; sits between the mux and the counter/display logic.

Parameters:
- DIV, 4, dwell length in clk cycles with mux enable high per channel; legal range ≥1.
- BLANK, 2, cycles with mux enable low after each select change; 0 allowed (no gap).
- CNT_W, 16, width of the internal cycle counter; must hold max(DIV, BLANK).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run request; level-sensitive
- ch_mask  input  4  channel enable mask; bit i=1 includes mux input i in the sweep
- mux_y  input  1  mux output Y
- sel  output  2  drives mux S
- mux_en  output  1  drives mux E
- sample  output  4  last published sweep result; bit i = Y captured on channel i
- sample_valid  output  1  one-cycle pulse when sample updates
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - sel=0, mux_en=0, sample=0, sample_valid=0, busy=0.
  - Internal state: state=IDLE, counter=0, done=0, shadow=0.
- All other state changes occur on the rising edge of clk. All outputs are registered.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - mux_en=0; sel holds its value.
  - If en=1 and ch_mask≠0, load sel with the lowest set bit of ch_mask.
  - Then go to BLANK, or directly to DRIVE if BLANK=0.
- BLANK:
  - mux_en=0; counter counts BLANK cycles.
  - After the BLANK-th cycle, go to DRIVE.
- DRIVE:
  - mux_en=1 for exactly DIV cycles.
  - On the last DRIVE cycle, capture mux_y into shadow[sel] and set done[sel].
- Advance, evaluated on the same edge that ends DRIVE:
  - Next sel = the next set bit of the current ch_mask above the current sel, wrapping to the lowest set bit.
  - If only one bit is set, sel stays put and BLANK still occurs.
- Sweep completion:
  - Occurs when (done & ch_mask) == ch_mask after the capture.
  - Copy shadow into sample, with bits outside ch_mask forced to 0.
  - Pulse sample_valid on the following cycle. Clear done.
  - Continue the next sweep without passing through IDLE.
- Latency:
  - en sampled high → first mux_en=1 after 1+BLANK cycles.
  - First sample_valid = 1 + popcount(mask)·(BLANK+DIV) cycles after en is sampled.
- Boundary conditions:
  - en=0 in BLANK or DRIVE: go to IDLE next edge, mux_en=0, done cleared. sample is unchanged and no sample_valid is issued for the partial sweep.
  - ch_mask=0 at advance: go to IDLE, no publish.
  - ch_mask change mid-sweep: takes effect at the next advance. done bits for channels no longer in the mask are ignored. A newly added channel must be sampled before completion.
  - en=1 with ch_mask=0 in IDLE: remain in IDLE.
  - Capture and abort on the same edge: abort wins; no capture, no publish.
  - sel never changes while mux_en=1.
  - mux_en falls on the same edge that sel updates, so mux_en is always 0 in the first cycle of a new sel (when BLANK≥1).
  - rst_n asserted mid-operation: immediate return to reset values regardless of state.

Test Plan (DIV=4, BLANK=2):
1. Reset: hold rst_n=0 with en=1 → sel=0, mux_en=0, sample=0, busy=0. Release rst_n and raise en with ch_mask=1111 → busy=1 next cycle, mux_en=1 from cycle 3 to cycle 6.
2. Full sweep: ch_mask=1111 with mux_y driven as Y = I[sel], I=1010 →
   - sel order 0,1,2,3.
   - Each channel: 2 blank cycles then 4 enabled cycles.
   - sample_valid pulses once at cycle 25 with sample=1010.
   - Sweep repeats.
3. Sparse mask: ch_mask=0101, I=0100 → sel alternates 0,2; sample=0100 every 12 cycles; sel never equals 1 or 3.
4. Abort: drop en on DRIVE cycle 2 of channel 2 → mux_en=0 and busy=0 next cycle; no sample_valid; sample retains the previous value. Re-raising en restarts at sel=0.
5. Mask change mid-sweep: ch_mask 1111→0011 during channel 1 DRIVE → next sel=0 and sweep completes; sample bits 3:2 = 0.
6. Single channel plus BLANK=0 build: ch_mask=1000 → sel stays 3, mux_en constantly 1 after the first cycle, sample_valid every 4 cycles.
